// File: rtl/mul_add_seq.sv
// mul_add_seq: sequential shift-add multiply-accumulate.
//   numerator = low N_WIDTH bits of (quotient * denominator + remain)
// One denominator bit is consumed per clock, so an operation takes D_WIDTH
// cycles in CALC. This rebuilds a linear cell index from a quotient/remainder
// pair, which is the inverse of the divider.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   quotient     multiplicand (N_WIDTH), captured on accepted start
//   denominator  multiplier (D_WIDTH), captured on accepted start
//   remain       addend (D_WIDTH), captured on accepted start
//   busy         high while an operation is in progress
//   valid        one-cycle pulse when the result outputs update
//   numerator    result, low N_WIDTH bits
//   overflow     full result did not fit in N_WIDTH bits
//   rem_err      captured remain >= captured denominator
module mul_add_seq #(
  parameter int N_WIDTH = 8,
  parameter int D_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_WIDTH-1:0] quotient,
  input  logic [D_WIDTH-1:0] denominator,
  input  logic [D_WIDTH-1:0] remain,
  output logic               busy,
  output logic               valid,
  output logic [N_WIDTH-1:0] numerator,
  output logic               overflow,
  output logic               rem_err
);

  // The accumulator is wide enough that (2^N-1)(2^D-1)+(2^D-1) never wraps.
  localparam int A_W = N_WIDTH + D_WIDTH;
  localparam int C_W = $clog2(D_WIDTH) + 1;
  localparam logic [C_W-1:0] LAST_CNT = C_W'(D_WIDTH - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t             state_reg, state_next;
  logic [A_W-1:0]     acc_reg, acc_next;
  logic [A_W-1:0]     mcand_reg, mcand_next;
  logic [D_WIDTH-1:0] mplier_reg, mplier_next;
  logic [C_W-1:0]     cnt_reg, cnt_next;
  // remain >= denominator is decided at capture time so the raw operands
  // need not be kept around for the whole operation.
  logic               rerr_pend_reg, rerr_pend_next;
  logic               busy_reg, busy_next;
  logic               valid_reg, valid_next;
  logic [N_WIDTH-1:0] num_reg, num_next;
  logic               ovf_reg, ovf_next;
  logic               rem_err_reg, rem_err_next;

  logic [A_W-1:0]     acc_sum;

  // This cycle's partial-product add; also the final value on the last cycle.
  assign acc_sum = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      cnt_reg       <= '0;
      rerr_pend_reg <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      num_reg       <= '0;
      ovf_reg       <= 1'b0;
      rem_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      cnt_reg       <= cnt_next;
      rerr_pend_reg <= rerr_pend_next;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      num_reg       <= num_next;
      ovf_reg       <= ovf_next;
      rem_err_reg   <= rem_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    cnt_next       = cnt_reg;
    rerr_pend_next = rerr_pend_reg;
    busy_next      = busy_reg;
    valid_next     = 1'b0;
    num_next       = num_reg;
    ovf_next       = ovf_reg;
    rem_err_next   = rem_err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          acc_next       = {{N_WIDTH{1'b0}}, remain};
          mcand_next     = {{D_WIDTH{1'b0}}, quotient};
          mplier_next    = denominator;
          cnt_next       = '0;
          rerr_pend_next = (remain >= denominator);
          busy_next      = 1'b1;
          state_next     = CALC;
        end
      end
      CALC: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + C_W'(1);
        if (cnt_reg == LAST_CNT) begin
          num_next     = acc_sum[N_WIDTH-1:0];
          ovf_next     = |acc_sum[A_W-1:N_WIDTH];
          rem_err_next = rerr_pend_reg;
          valid_next   = 1'b1;
          busy_next    = 1'b0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign valid     = valid_reg;
  assign numerator = num_reg;
  assign overflow  = ovf_reg;
  assign rem_err   = rem_err_reg;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed and randomized bench for mul_add_seq. Expected results come from
// plain integer arithmetic: full = q*d + r.
module tb_mul_add_seq;
  localparam int NW = 8;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] quotient;
  logic [DW-1:0] denominator;
  logic [DW-1:0] remain;
  logic          busy, valid, overflow, rem_err;
  logic [NW-1:0] numerator;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_add_seq #(.N_WIDTH(NW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .quotient(quotient), .denominator(denominator), .remain(remain),
    .busy(busy), .valid(valid), .numerator(numerator),
    .overflow(overflow), .rem_err(rem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full request/response: start pulse before edge E, busy for DW cycles,
  // valid with the model result in the cycle after E+DW, then valid drops.
  task automatic run_op(input int q, input int d, input int r);
    int full;
    full = q * d + r;
    @(negedge clk);
    quotient = NW'(q); denominator = DW'(d); remain = DW'(r); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_c1", busy, 1);
    check("valid_c1", valid, 0);
    for (int i = 1; i < DW; i++) begin
      @(negedge clk);
      check("busy_cn", busy, 1);
      check("valid_cn", valid, 0);
    end
    @(negedge clk);
    check("busy_done", busy, 0);
    check("valid_done", valid, 1);
    check("numerator", numerator, full % (1 << NW));
    check("overflow", overflow, (full >= (1 << NW)) ? 1 : 0);
    check("rem_err", rem_err, (r >= d) ? 1 : 0);
    @(negedge clk);
    check("valid_drop", valid, 0);
    $display("op q=%0d d=%0d r=%0d -> num=%0d ovf=%0b rerr=%0b", q, d, r,
             numerator, overflow, rem_err);
  endtask

  initial begin
    start = 1'b0; quotient = '0; denominator = '0; remain = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_num", numerator, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rerr", rem_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the plan.
    run_op(42, 3, 2);
    run_op(255, 3, 2);
    run_op(9, 0, 1);
    run_op(10, 2, 3);

    // Second start while busy is ignored and not queued.
    @(negedge clk);
    quotient = 8'd5; denominator = 2'd2; remain = 2'd1; start = 1'b1;
    @(negedge clk);
    check("ign_busy1", busy, 1);
    quotient = 8'd7; denominator = 2'd3; remain = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_busy2", busy, 1);
    @(negedge clk);
    check("ign_valid", valid, 1);
    check("ign_num", numerator, 11);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign_noq_valid", valid, 0);
      check("ign_noq_busy", busy, 0);
    end
    $display("ignored-start case: num=11 expected, only one valid");

    // Back-to-back with start held high: one result every DW+1 cycles.
    @(negedge clk);
    quotient = 8'd20; denominator = 2'd3; remain = 2'd1; start = 1'b1;
    for (int k = 1; k <= 3 * (DW + 1); k++) begin
      @(negedge clk);
      if (k % (DW + 1) == 0) begin
        check("b2b_valid", valid, 1);
        check("b2b_busy", busy, 0);
        check("b2b_num", numerator, 61);
        $display("b2b result at cycle %0d num=%0d", k, numerator);
      end else begin
        check("b2b_valid0", valid, 0);
        check("b2b_busy1", busy, 1);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_stop", busy, 0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    quotient = 8'd100; denominator = 2'd3; remain = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ab_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ab_busy0", busy, 0);
    check("ab_valid0", valid, 0);
    check("ab_num0", numerator, 0);
    check("ab_ovf0", overflow, 0);
    check("ab_rerr0", rem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DW + 2; i++) begin
      @(negedge clk);
      check("ab_novalid", valid, 0);
    end
    $display("reset abort case done");
    run_op(3, 1, 0);

    // Randomized operands.
    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, (1 << NW) - 1)),
             int'($urandom_range(0, (1 << DW) - 1)),
             int'($urandom_range(0, (1 << DW) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
